// File: rtl/knight_scanner_pkg.sv
// Shared constants for the Knight Rider LED scanner: motion-mode encodings,
// direction encodings and the brightness ceiling helper.
package knight_pkg;

   localparam logic [1:0] MODE_BOUNCE = 2'b00;
   localparam logic [1:0] MODE_WRAP_L = 2'b01;
   localparam logic [1:0] MODE_WRAP_R = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   localparam logic DIR_LEFT  = 1'b1;   // index counts up
   localparam logic DIR_RIGHT = 1'b0;   // index counts down

   // Full-on brightness for a level register of the given width.
   function automatic int lmax(input int level_w);
      return (1 << level_w) - 1;
   endfunction

endpackage

// File: rtl/knight_scanner_if.sv
// Step/mode inputs and LED/position outputs of the scanner, bundled so the
// prescaler side (master) and the scanner (slave) share one port list.
interface knight_scanner_if #(
   parameter int OUT_WIDTH = 8
) ();

   localparam int HEAD_W = $clog2(OUT_WIDTH);

   logic                 enable;
   logic                 next_pos;
   logic [1:0]           mode;
   logic [OUT_WIDTH-1:0] leds;
   logic [HEAD_W-1:0]    head_pos;
   logic                 dir;
   logic                 turn;

   modport master (
      output enable, next_pos, mode,
      input  leds, head_pos, dir, turn
   );

   modport slave (
      input  enable, next_pos, mode,
      output leds, head_pos, dir, turn
   );

endinterface

// File: rtl/knight_scanner_pwm.sv
// Free-running PWM counter and per-LED brightness compare. A level of LMAX is
// always on, 0 is always off, level k is on for k of every LMAX cycles.
module knight_pwm
   import knight_pkg::*;
#(
   parameter int OUT_WIDTH = 8,
   parameter int LEVEL_W   = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              enable,
   input  logic [OUT_WIDTH-1:0][LEVEL_W-1:0] levels,
   output logic [OUT_WIDTH-1:0]              leds
);

   localparam int                 LMAX    = lmax(LEVEL_W);
   localparam logic [LEVEL_W-1:0] CNT_TOP = LEVEL_W'(LMAX - 1);
   localparam logic [LEVEL_W-1:0] CNT_ONE = LEVEL_W'(1);

   logic [LEVEL_W-1:0] pwm_cnt_q, pwm_cnt_d;

   // Counter runs 0..LMAX-1 and wraps, giving a period of LMAX cycles.
   always_comb begin
      pwm_cnt_d = (pwm_cnt_q == CNT_TOP) ? '0 : pwm_cnt_q + CNT_ONE;
   end

   // PWM phase register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pwm_cnt_q <= '0;
      else          pwm_cnt_q <= pwm_cnt_d;
   end

   // LEDs blank while reset is held so the drive goes dark the instant reset asserts.
   always_comb begin
      for (int i = 0; i < OUT_WIDTH; i++) begin
         leds[i] = reset_n & enable & (levels[i] > pwm_cnt_q);
      end
   end

endmodule

// File: rtl/knight_scanner.sv
// Knight Rider LED scanner: moves a head across OUT_WIDTH LEDs under a step
// strobe, with bounce / wrap-left / wrap-right / hold motion modes.
// Build option KNIGHT_SCANNER_TAIL_EN: when defined, each LED keeps a
// brightness level that decays by DECAY per step, leaving a fading tail;
// when undefined, no level registers exist and only the head is lit.
module knight_scanner
   import knight_pkg::*;
#(
   parameter int OUT_WIDTH = 8,
   parameter int LEVEL_W   = 4,
   parameter int DECAY     = 4
) (
   input logic             clk,
   input logic             reset_n,
   knight_scanner_if.slave bus
);

   localparam int                 HEAD_W     = $clog2(OUT_WIDTH);
   localparam int                 LMAX       = lmax(LEVEL_W);
   localparam logic [HEAD_W-1:0]  POS_MAX    = HEAD_W'(OUT_WIDTH - 1);
   localparam logic [HEAD_W-1:0]  POS_ONE    = HEAD_W'(1);
   localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(LMAX);

   if (OUT_WIDTH < 2 || OUT_WIDTH > 32) begin : g_chk_width
      $error("knight_scanner: OUT_WIDTH must be 2..32");
   end
   if (DECAY < 1 || DECAY > LMAX) begin : g_chk_decay
      $error("knight_scanner: DECAY must be 1..LMAX");
   end

   logic [HEAD_W-1:0] pos_q, pos_d;
   logic              dir_q, dir_d;
   logic              turn_q, turn_d;

   logic [OUT_WIDTH-1:0][LEVEL_W-1:0] levels_w;
   logic [OUT_WIDTH-1:0]              leds_w;

   // Head motion: next position, direction and turn flag for the sampled mode.
   // NOTE: every output gets a default first so no path through the case leaves a latch.
   always_comb begin
      pos_d  = pos_q;
      dir_d  = dir_q;
      turn_d = 1'b0;
      if (bus.next_pos) begin
         case (bus.mode)
            MODE_BOUNCE: begin
               if (dir_q == DIR_LEFT) begin
                  if (pos_q == POS_MAX) begin
                     // Entered bounce already parked on the far end: reverse rather than overshoot.
                     pos_d  = pos_q - POS_ONE;
                     dir_d  = DIR_RIGHT;
                     turn_d = 1'b1;
                  end else begin
                     pos_d = pos_q + POS_ONE;
                     if (pos_d == POS_MAX) begin
                        dir_d  = DIR_RIGHT;
                        turn_d = 1'b1;
                     end
                  end
               end else begin
                  if (pos_q == '0) begin
                     pos_d  = POS_ONE;
                     dir_d  = DIR_LEFT;
                     turn_d = 1'b1;
                  end else begin
                     pos_d = pos_q - POS_ONE;
                     if (pos_d == '0) begin
                        dir_d  = DIR_LEFT;
                        turn_d = 1'b1;
                     end
                  end
               end
            end
            MODE_WRAP_L: begin
               dir_d = DIR_LEFT;
               if (pos_q == POS_MAX) begin
                  pos_d  = '0;
                  turn_d = 1'b1;
               end else begin
                  pos_d = pos_q + POS_ONE;
               end
            end
            MODE_WRAP_R: begin
               dir_d = DIR_RIGHT;
               if (pos_q == '0) begin
                  pos_d  = POS_MAX;
                  turn_d = 1'b1;
               end else begin
                  pos_d = pos_q - POS_ONE;
               end
            end
            default: begin
               // Hold: position and direction stay put.
            end
         endcase
      end
   end

   // Position, direction and turn registers.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_q  <= '0;
         dir_q  <= DIR_LEFT;
         turn_q <= 1'b0;
      end else begin
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         turn_q <= turn_d;
      end
   end

`ifdef KNIGHT_SCANNER_TAIL_EN
   localparam logic [LEVEL_W-1:0] LEVEL_DECAY = LEVEL_W'(DECAY);

   logic [OUT_WIDTH-1:0][LEVEL_W-1:0] level_q, level_d;

   // On each step the new head goes full bright and every other LED fades, floored at 0.
   always_comb begin
      level_d = level_q;
      if (bus.next_pos) begin
         for (int i = 0; i < OUT_WIDTH; i++) begin
            if (HEAD_W'(i) == pos_d)
               level_d[i] = LEVEL_FULL;
            else if (level_q[i] > LEVEL_DECAY)
               level_d[i] = level_q[i] - LEVEL_DECAY;
            else
               level_d[i] = '0;
         end
      end
   end

   // Brightness level registers.
   // NOTE: this is a handful of flops, not a RAM, so resetting the whole array is cheap and intended.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q    <= '0;
         level_q[0] <= LEVEL_FULL;
      end else begin
         level_q <= level_d;
      end
   end

   assign levels_w = level_q;
`else
   // Single-dot scanner: only the head is lit, at full brightness.
   always_comb begin
      for (int i = 0; i < OUT_WIDTH; i++) begin
         levels_w[i] = (HEAD_W'(i) == pos_q) ? LEVEL_FULL : '0;
      end
   end
`endif

   knight_pwm #(
      .OUT_WIDTH (OUT_WIDTH),
      .LEVEL_W   (LEVEL_W)
   ) u_pwm (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (bus.enable),
      .levels  (levels_w),
      .leds    (leds_w)
   );

   assign bus.leds     = leds_w;
   assign bus.head_pos = pos_q;
   assign bus.dir      = dir_q;
   assign bus.turn     = turn_q;

endmodule

// File: tb/tb_knight_scanner.sv
// Self-checking bench for knight_scanner: a behavioural model (integer
// position, direction, level array, PWM phase) tracks the scanner and a
// compare process checks every output on each falling edge; directed
// sequences pin the model with hand-computed values, then random stimulus runs.
module tb_knight_scanner;
   import knight_pkg::*;

   localparam int N    = 8;
   localparam int LW   = 4;
   localparam int DEC  = 4;
   localparam int LMAX = 15;
`ifdef KNIGHT_SCANNER_TAIL_EN
   localparam bit TAIL = 1'b1;
`else
   localparam bit TAIL = 1'b0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   knight_scanner_if #(.OUT_WIDTH(N)) bus ();

   knight_scanner #(
      .OUT_WIDTH (N),
      .LEVEL_W   (LW),
      .DECAY     (DEC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;
   bit run_cmp = 1'b0;

   // Behavioural model state
   int m_pos  = 0;
   bit m_dir  = 1'b1;
   bit m_turn = 1'b0;
   int m_pwm  = 0;
   int m_lvl[N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_pos  = 0;
      m_dir  = 1'b1;
      m_turn = 1'b0;
      m_pwm  = 0;
      for (int i = 0; i < N; i++) m_lvl[i] = (i == 0) ? LMAX : 0;
   endfunction

   function automatic void model_step(input logic [1:0] md);
      int np;
      bit nd;
      bit t;
      np = m_pos;
      nd = m_dir;
      t  = 1'b0;
      case (md)
         MODE_BOUNCE: begin
            np = m_dir ? m_pos + 1 : m_pos - 1;
            if (np > N - 1 || np < 0) begin
               np = m_dir ? m_pos - 1 : m_pos + 1;
               nd = !m_dir;
               t  = 1'b1;
            end else if ((m_dir && np == N - 1) || (!m_dir && np == 0)) begin
               nd = !m_dir;
               t  = 1'b1;
            end
         end
         MODE_WRAP_L: begin
            np = (m_pos + 1) % N;
            nd = 1'b1;
            t  = (np == 0);
         end
         MODE_WRAP_R: begin
            np = (m_pos + N - 1) % N;
            nd = 1'b0;
            t  = (np == N - 1);
         end
         default: ;
      endcase
      for (int i = 0; i < N; i++) begin
         if (i == np) m_lvl[i] = LMAX;
         else         m_lvl[i] = (m_lvl[i] > DEC) ? m_lvl[i] - DEC : 0;
      end
      m_pos  = np;
      m_dir  = nd;
      m_turn = t;
   endfunction

   function automatic logic [N-1:0] exp_leds();
      logic [N-1:0] e;
      bit on;
      for (int i = 0; i < N; i++) begin
         on   = TAIL ? (m_lvl[i] > m_pwm) : (i == m_pos);
         e[i] = on & bus.enable & reset_n;
      end
      return e;
   endfunction

   // Model advances on the same edges as the DUT.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         m_pwm  = (m_pwm + 1) % LMAX;
         m_turn = 1'b0;
         if (bus.next_pos) model_step(bus.mode);
      end
   end

   // Compare process: every output, every falling edge.
   always @(negedge clk) begin
      if (run_cmp) begin
         check("leds",     64'(bus.leds),     64'(exp_leds()));
         check("head_pos", 64'(bus.head_pos), 64'(m_pos));
         check("dir",      64'(bus.dir),      64'(m_dir));
         check("turn",     64'(bus.turn),     64'(m_turn));
      end
   end

   // One clock edge with the given inputs; returns just after that edge.
   task automatic tick(input bit np, input logic [1:0] md, input bit en);
      @(negedge clk);
      #1;
      bus.next_pos = np;
      bus.mode     = md;
      bus.enable   = en;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      bus.next_pos = 1'b0;
      reset_n      = 1'b0;
      @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int exp_pos[14];
      int cnt0, cnt1, cnt3, hits;
      logic [1:0] cur_mode;

      exp_pos = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
      bus.enable   = 1'b1;
      bus.next_pos = 1'b0;
      bus.mode     = MODE_BOUNCE;
      model_reset();
      #1 reset_n = 1'b0;
      run_cmp = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;

      // 1: idle after reset, head parked at 0 and fully on
      hits = 0;
      for (int k = 0; k < 20; k++) begin
         tick(1'b0, MODE_BOUNCE, 1'b1);
         if (bus.leds == 8'h01 && bus.head_pos == 0 && bus.dir == 1'b1) hits++;
      end
      check("idle_leds_01", 64'(hits), 64'd20);

      // 2: bounce sweep 1..7..0 with turn pulses at both ends
      for (int k = 0; k < 14; k++) begin
         tick(1'b1, MODE_BOUNCE, 1'b1);
         check("bounce_pos",  64'(bus.head_pos), 64'(exp_pos[k]));
         check("bounce_turn", 64'(bus.turn),     64'((k == 6 || k == 13) ? 1 : 0));
         check("bounce_dir",  64'(bus.dir),      64'((k < 6 || k == 13) ? 1 : 0));
      end
      tick(1'b0, MODE_BOUNCE, 1'b1);
      check("turn_one_cycle", 64'(bus.turn), 64'd0);

      // 3: tail after three steps from reset
      do_reset();
      repeat (3) tick(1'b1, MODE_BOUNCE, 1'b1);
      check("model_lvl0", 64'(m_lvl[0]), 64'd3);
      check("model_lvl1", 64'(m_lvl[1]), 64'd7);
      check("model_lvl2", 64'(m_lvl[2]), 64'd11);
      check("model_lvl3", 64'(m_lvl[3]), 64'd15);
      cnt0 = 0; cnt1 = 0; cnt3 = 0;
      for (int k = 0; k < 15; k++) begin
         tick(1'b0, MODE_BOUNCE, 1'b1);
         cnt0 += int'(bus.leds[0]);
         cnt1 += int'(bus.leds[1]);
         cnt3 += int'(bus.leds[3]);
      end
      check("duty_led1", 64'(cnt1), TAIL ? 64'd7 : 64'd0);
      check("duty_led0", 64'(cnt0), TAIL ? 64'd3 : 64'd0);
      check("duty_led3", 64'(cnt3), 64'd15);

      // 4: mode change at pos 3 heading left, then wraps both ways
      tick(1'b1, MODE_WRAP_R, 1'b1);
      check("modechg_pos", 64'(bus.head_pos), 64'd2);
      check("modechg_dir", 64'(bus.dir),      64'd0);
      repeat (2) tick(1'b1, MODE_WRAP_R, 1'b1);
      check("wrapr_at0",   64'(bus.head_pos), 64'd0);
      check("wrapr_noturn", 64'(bus.turn),    64'd0);
      tick(1'b1, MODE_WRAP_R, 1'b1);
      check("wrapr_pos",  64'(bus.head_pos), 64'd7);
      check("wrapr_dir",  64'(bus.dir),      64'd0);
      check("wrapr_turn", 64'(bus.turn),     64'd1);
      tick(1'b1, MODE_WRAP_L, 1'b1);
      check("wrapl_pos",  64'(bus.head_pos), 64'd0);
      check("wrapl_dir",  64'(bus.dir),      64'd1);
      check("wrapl_turn", 64'(bus.turn),     64'd1);

      // 5: hold keeps the head and lets the tail die out without underflow
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, MODE_HOLD, 1'b1);
         check("hold_pos",  64'(bus.head_pos), 64'd0);
         check("hold_turn", 64'(bus.turn),     64'd0);
      end
      check("hold_head_lvl", 64'(m_lvl[0]), 64'd15);
      hits = 0;
      for (int i = 1; i < N; i++) hits += m_lvl[i];
      check("hold_tail_zero", 64'(hits), 64'd0);
      hits = 0;
      for (int k = 0; k < 15; k++) begin
         tick(1'b0, MODE_HOLD, 1'b1);
         if (bus.leds == 8'h01) hits++;
      end
      check("hold_leds_01", 64'(hits), 64'd15);

      // 6: asynchronous reset mid-sweep, then stepping with outputs disabled
      repeat (3) tick(1'b1, MODE_BOUNCE, 1'b1);
      check("pre_reset_pos", 64'(bus.head_pos), 64'd3);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_rst_leds", 64'(bus.leds),     64'd0);
      check("async_rst_pos",  64'(bus.head_pos), 64'd0);
      check("async_rst_dir",  64'(bus.dir),      64'd1);
      bus.next_pos = 1'b0;
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      tick(1'b0, MODE_BOUNCE, 1'b1);
      check("post_rst_leds", 64'(bus.leds), 64'h01);
      for (int k = 1; k <= 5; k++) begin
         tick(1'b1, MODE_BOUNCE, 1'b0);
         check("dis_leds", 64'(bus.leds),     64'd0);
         check("dis_pos",  64'(bus.head_pos), 64'(k));
      end

      // Random phase
      cur_mode = MODE_BOUNCE;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 7) == 0) cur_mode = 2'($urandom_range(0, 3));
         tick($urandom_range(0, 9) < 6, cur_mode, $urandom_range(0, 9) != 0);
      end

      @(negedge clk);
      #1;
      run_cmp = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
